mor1kx_rf_wrarb_marocchino: RTL and testbench

Arbitrates the single MAROCCHINO GPR write port between NUM_REQ writeback sources (1-clk ALU, LSU, MUL, DIV) and the SPR-bus GPR access path. Picks one valid source per cycle and registers its result onto the wb_* write-port signals consumed by the register file. Holds SPR-bus GPR accesses until the write port is idle, then forwards them to the register file and returns the acknowledge.

---
 rtl/mor1kx_rf_wrarb_marocchino.sv | 174 +++++++++++++++++
 tb/tb_mor1kx_rf_wrarb_marocchino.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mor1kx_rf_wrarb_marocchino.sv
// GPR write-port arbiter: round-robin pick of one writeback source per cycle, registered onto wb_*,
// with SPR-bus GPR accesses held until the port drains. Define MOR1KX_RF_WRARB_FIXED_PRIO_EN for fixed priority.
module mor1kx_rf_wrarb_marocchino #(
    parameter int NUM_REQ              = 4,
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int OPTION_RF_ADDR_WIDTH = 5
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    pipeline_flush_i,
    input  logic [NUM_REQ-1:0]                      req_valid_i,
    input  logic [NUM_REQ*OPTION_RF_ADDR_WIDTH-1:0] req_adr_i,
    input  logic [NUM_REQ*OPTION_OPERAND_WIDTH-1:0] req_dat_i,
    output logic [NUM_REQ-1:0]                      req_ready_o,
    output logic                                    wb_rf_wb_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0]         wb_rfd_adr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]         wb_result_o,
    output logic                                    wb_new_result_o,
    input  logic [15:0]                             spr_bus_addr_i,
    input  logic                                    spr_bus_stb_i,
    input  logic                                    spr_bus_we_i,
    output logic                                    spr_gpr_stb_o,
    input  logic                                    rf_spr_ack_i,
    output logic                                    spr_gpr_ack_o
);
    // state      | meaning
    // SPR_IDLE   | no SPR GPR access; grants allowed
    // SPR_DRAIN  | GPR access seen; grants blocked until wb stage is idle
    // SPR_ACCESS | strobe forwarded to register file, waiting for its ack
    // SPR_DONE   | ack returned to SPR bus for one clock
    localparam int AW = OPTION_RF_ADDR_WIDTH;
    localparam int DW = OPTION_OPERAND_WIDTH;
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {SPR_IDLE, SPR_DRAIN, SPR_ACCESS, SPR_DONE} spr_state_e;

    spr_state_e    state_q;
    logic          spr_stb_q;
    logic          spr_ack_q;
    logic          need_low_q;
    logic          wb_new_q;
    logic          wb_rf_wb_q;
    logic [AW-1:0] wb_adr_q;
    logic [DW-1:0] wb_dat_q;

    logic          gpr_hit;
    logic          grant_en;
    logic          grant_found;
    logic          grant_any;
    logic [PW-1:0] grant_idx;
    logic [PW-1:0] start_idx;
    logic [PW-1:0] cand;
    logic [PW:0]   sum;
    logic [AW-1:0] adr_sel;
    logic [DW-1:0] dat_sel;
    logic          unused_ok;

`ifdef MOR1KX_RF_WRARB_FIXED_PRIO_EN
    assign start_idx = '0;
`else
    logic [PW-1:0] rr_ptr_q;
    logic [PW-1:0] rr_ptr_d;
    assign start_idx = rr_ptr_q;
    assign rr_ptr_d  = (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
`endif

    assign gpr_hit  = spr_bus_stb_i & (spr_bus_addr_i[15:9] == 7'h2);
    // DRAIN with the strobe gone is an aborted access, so the port is free again
    assign grant_en = !pipeline_flush_i &&
                      ((state_q == SPR_IDLE) || ((state_q == SPR_DRAIN) && !spr_bus_stb_i));

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        sum         = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, start_idx} + (PW+1)'(k);
            if (sum >= (PW+1)'(NUM_REQ))
                sum = sum - (PW+1)'(NUM_REQ);
            cand = sum[PW-1:0];
            if (!grant_found && req_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign grant_any   = grant_en & grant_found;
    assign req_ready_o = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
    assign adr_sel     = req_adr_i[int'(grant_idx)*AW +: AW];
    assign dat_sel     = req_dat_i[int'(grant_idx)*DW +: DW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_new_q   <= 1'b0;
            wb_rf_wb_q <= 1'b0;
            wb_adr_q   <= '0;
            wb_dat_q   <= '0;
`ifndef MOR1KX_RF_WRARB_FIXED_PRIO_EN
            rr_ptr_q   <= '0;
`endif
        end else if (pipeline_flush_i) begin
            wb_new_q   <= 1'b0;
            wb_rf_wb_q <= 1'b0;
`ifndef MOR1KX_RF_WRARB_FIXED_PRIO_EN
            rr_ptr_q   <= '0;
`endif
        end else if (grant_any) begin
            wb_new_q   <= 1'b1;
            wb_rf_wb_q <= |adr_sel;
            wb_adr_q   <= adr_sel;
            wb_dat_q   <= dat_sel;
`ifndef MOR1KX_RF_WRARB_FIXED_PRIO_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end else begin
            wb_new_q   <= 1'b0;
            wb_rf_wb_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SPR_IDLE;
            spr_stb_q  <= 1'b0;
            spr_ack_q  <= 1'b0;
            need_low_q <= 1'b0;
        end else begin
            spr_ack_q <= 1'b0;
            if (!spr_bus_stb_i)
                need_low_q <= 1'b0;
            case (state_q)
                SPR_IDLE: begin
                    if (gpr_hit && !need_low_q)
                        state_q <= SPR_DRAIN;
                end
                SPR_DRAIN: begin
                    if (!spr_bus_stb_i) begin
                        state_q <= SPR_IDLE;
                    end else if (!wb_new_q) begin
                        state_q   <= SPR_ACCESS;
                        spr_stb_q <= 1'b1;
                    end
                end
                SPR_ACCESS: begin
                    if (!spr_bus_stb_i) begin
                        state_q   <= SPR_IDLE;
                        spr_stb_q <= 1'b0;
                    end else if (rf_spr_ack_i) begin
                        state_q   <= SPR_DONE;
                        spr_stb_q <= 1'b0;
                        spr_ack_q <= 1'b1;
                    end
                end
                SPR_DONE: begin
                    // the bus must drop its strobe before another access is taken
                    state_q    <= SPR_IDLE;
                    need_low_q <= 1'b1;
                end
                default: state_q <= SPR_IDLE;
            endcase
        end
    end

    assign wb_new_result_o = wb_new_q;
    assign wb_rf_wb_o      = wb_rf_wb_q;
    assign wb_rfd_adr_o    = wb_adr_q;
    assign wb_result_o     = wb_dat_q;
    assign spr_gpr_stb_o   = spr_stb_q;
    assign spr_gpr_ack_o   = spr_ack_q;
    assign unused_ok       = ^{spr_bus_we_i, spr_bus_addr_i[8:0]};

endmodule

// File: tb/tb_mor1kx_rf_wrarb_marocchino.sv
// Scoreboard bench for the GPR write-port arbiter: a queue-based source model predicts grants and writes.
module tb_mor1kx_rf_wrarb_marocchino;
    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            pipeline_flush_i = 1'b0;
    logic [N-1:0]    req_valid_i = '0;
    logic [N*AW-1:0] req_adr_i = '0;
    logic [N*DW-1:0] req_dat_i = '0;
    logic [N-1:0]    req_ready_o;
    logic            wb_rf_wb_o;
    logic [AW-1:0]   wb_rfd_adr_o;
    logic [DW-1:0]   wb_result_o;
    logic            wb_new_result_o;
    logic [15:0]     spr_bus_addr_i = '0;
    logic            spr_bus_stb_i = 1'b0;
    logic            spr_bus_we_i = 1'b0;
    logic            spr_gpr_stb_o;
    logic            rf_spr_ack_i = 1'b0;
    logic            spr_gpr_ack_o;

    mor1kx_rf_wrarb_marocchino #(.NUM_REQ(N), .OPTION_OPERAND_WIDTH(DW), .OPTION_RF_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .pipeline_flush_i(pipeline_flush_i),
        .req_valid_i(req_valid_i), .req_adr_i(req_adr_i), .req_dat_i(req_dat_i),
        .req_ready_o(req_ready_o), .wb_rf_wb_o(wb_rf_wb_o), .wb_rfd_adr_o(wb_rfd_adr_o),
        .wb_result_o(wb_result_o), .wb_new_result_o(wb_new_result_o),
        .spr_bus_addr_i(spr_bus_addr_i), .spr_bus_stb_i(spr_bus_stb_i), .spr_bus_we_i(spr_bus_we_i),
        .spr_gpr_stb_o(spr_gpr_stb_o), .rf_spr_ack_i(rf_spr_ack_i), .spr_gpr_ack_o(spr_gpr_ack_o));

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // source model: each source either has one pending write or none
    bit            pend[N];
    logic [AW-1:0] p_adr[N];
    logic [DW-1:0] p_dat[N];
    int            rr = 0;
    bit            blk = 1'b0;
    bit            refill = 1'b0;
    bit            always_on = 1'b0;
    int            stream_src = -1;
    int            flush_pct = 0;

    bit            s_flush = 1'b0;
    bit            s_stb = 1'b0;
    bit            s_we = 1'b0;
    bit            s_ack = 1'b0;
    logic [15:0]   s_addr = '0;

    typedef struct {logic [AW-1:0] adr; logic [DW-1:0] dat;} wr_t;
    wr_t expq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pend[i]  = 1'b1;
        p_adr[i] = a;
        p_dat[i] = d;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && refill && (stream_src < 0 || stream_src == i))
                if (always_on || ($urandom_range(1, 0) == 1))
                    load(i, AW'($urandom_range(31, 0)), $urandom);
            req_valid_i[i]           = pend[i];
            req_adr_i[i*AW +: AW]    = p_adr[i];
            req_dat_i[i*DW +: DW]    = p_dat[i];
        end
        if (flush_pct > 0)
            s_flush = ($urandom_range(99, 0) < flush_pct);
        pipeline_flush_i = s_flush;
        spr_bus_stb_i    = s_stb;
        spr_bus_addr_i   = s_addr;
        spr_bus_we_i     = s_we;
        rf_spr_ack_i     = s_ack;
    endtask

    // expected grant: first pending source scanning circularly from the pointer
    task automatic check_cycle();
        int g;
        int start;
        logic [N-1:0] exp_rdy;
        g = -1;
        exp_rdy = '0;
`ifdef MOR1KX_RF_WRARB_FIXED_PRIO_EN
        start = 0;
`else
        start = rr;
`endif
        if (!s_flush && !blk)
            for (int k = 0; k < N; k++)
                if (g < 0 && pend[(start + k) % N]) g = (start + k) % N;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 64'(req_ready_o), 64'(exp_rdy));
        if (g >= 0) begin
            expq.push_back('{adr: p_adr[g], dat: p_dat[g]});
            pend[g] = 1'b0;
            rr = (g + 1) % N;
        end else if (s_flush) begin
            rr = 0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        drive();
        #1;
        check_cycle();
    endtask

    initial begin : monitor
        wr_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && wb_new_result_o) begin
                if (expq.size() == 0) begin
                    chk("wb_unexpected", 64'(wb_new_result_o), 64'(0));
                end else begin
                    e = expq.pop_front();
                    chk("wb_adr", 64'(wb_rfd_adr_o), 64'(e.adr));
                    chk("wb_dat", 64'(wb_result_o), 64'(e.dat));
                    chk("wb_rf_wb", 64'(wb_rf_wb_o), 64'(e.adr != 0));
                end
            end
        end
    end

    initial begin : stimulus
        bit seen;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; p_adr[i] = '0; p_dat[i] = '0;
        end
        #12;
        chk("rst_ready", 64'(req_ready_o), 64'(0));
        chk("rst_wb", 64'({wb_rf_wb_o, wb_new_result_o, spr_gpr_stb_o, spr_gpr_ack_o}), 64'(0));
        chk("rst_adr_dat", 64'({wb_rfd_adr_o, wb_result_o}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // all sources held valid from reset: 0,1,2,3,0 (fixed priority: always 0)
        refill = 1'b1; always_on = 1'b1;
        repeat (5) cycle();
        refill = 1'b0; always_on = 1'b0;
        repeat (5) cycle();

        // single request from source 2
        load(2, 5'd3, 32'hDEADBEEF);
        cycle();
        chk("single_ready", 64'(req_ready_o), 64'(4'b0100));
        cycle();

        // write to r0
        load(0, 5'd0, 32'h5);
        cycle();
        cycle();

        // flush resets the pointer: source 0 wins next even after source 0 was last granted
        load(0, 5'd9, 32'h99);
        cycle();
        load(0, 5'd10, 32'hA0);
        load(1, 5'd11, 32'hB0);
        s_flush = 1'b1;
        cycle();
        s_flush = 1'b0;
        cycle();
        chk("flush_wb", 64'({wb_rf_wb_o, wb_new_result_o}), 64'(0));
        repeat (3) cycle();

        // non-GPR SPR address is ignored
        refill = 1'b1;
        s_stb = 1'b1; s_addr = 16'h0003;
        repeat (6) begin
            cycle();
            chk("nongpr_spr", 64'({spr_gpr_stb_o, spr_gpr_ack_o}), 64'(0));
        end
        s_stb = 1'b0;
        refill = 1'b0;
        repeat (6) cycle();

        // SPR read at 0x0403 while source 1 streams
        refill = 1'b1; always_on = 1'b1; stream_src = 1;
        repeat (2) cycle();
        s_stb = 1'b1; s_addr = 16'h0403; s_we = 1'b0;
        cycle();
        chk("spr_c0_stb", 64'(spr_gpr_stb_o), 64'(0));
        blk = 1'b1;
        cycle(); chk("spr_c1_stb", 64'(spr_gpr_stb_o), 64'(0));
        cycle(); chk("spr_c2_stb", 64'(spr_gpr_stb_o), 64'(0));
        cycle(); chk("spr_c3_stb", 64'(spr_gpr_stb_o), 64'(1));
        cycle(); chk("spr_c4_stb", 64'(spr_gpr_stb_o), 64'(1));
        s_ack = 1'b1;
        cycle(); chk("spr_c5", 64'({spr_gpr_stb_o, spr_gpr_ack_o}), 64'(2'b10));
        s_ack = 1'b0;
        cycle(); chk("spr_c6", 64'({spr_gpr_stb_o, spr_gpr_ack_o}), 64'(2'b01));
        s_stb = 1'b0; blk = 1'b0;
        cycle(); chk("spr_c7_ack", 64'(spr_gpr_ack_o), 64'(0));
        repeat (2) cycle();
        refill = 1'b0; always_on = 1'b0; stream_src = -1;
        repeat (4) cycle();

        // randomized traffic with occasional flushes
        refill = 1'b1; flush_pct = 10;
        repeat (300) cycle();
        refill = 1'b0; flush_pct = 0; s_flush = 1'b0;
        repeat (8) cycle();
        chk("queue_drained", 64'(expq.size()), 64'(0));

        // reset asserted while the SPR access is in progress
        s_stb = 1'b1; s_addr = 16'h0410; s_we = 1'b1; blk = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            cycle();
            seen = spr_gpr_stb_o;
        end
        chk("access_reached", 64'(spr_gpr_stb_o), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("rst_mid_wb", 64'({wb_rf_wb_o, wb_new_result_o, spr_gpr_stb_o, spr_gpr_ack_o}), 64'(0));
        chk("rst_mid_adr_dat", 64'({wb_rfd_adr_o, wb_result_o}), 64'(0));
        #20;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
